// File: rtl/uart_tx_buffered_if.sv
// Write-side handshake between a byte producer and uart_tx_buffered.
//   data_i       : byte to send, sampled with write_i
//   write_i      : write strobe
//   write_busy_o : holding register full; a write now is dropped
// master = producer, slave = transmitter.
interface uart_tx_buffered_if;
   logic [7:0] data_i;
   logic       write_i;
   logic       write_busy_o;

   modport master (output data_i, output write_i, input  write_busy_o);
   modport slave  (input  data_i, input  write_i, output write_busy_o);
endinterface

// File: rtl/uart_tx_buffered.sv
// UART transmitter with a one-byte holding register for gap-free
// back-to-back frames. Frame format (divider, parity, stop bits) is latched
// when a byte moves from the holding register into the shifter.
//   clock_i         : system clock, rising edge
//   reset_i         : asynchronous, active-low reset
//   clock_divider_i : clock cycles per serial bit (0 and 1 behave as 2)
//   two_stop_bits_i : 1 = two stop bits
//   parity_bit_i    : 1 = parity bit after the data bits
//   parity_even_i   : 1 = even parity, 0 = odd
//   wr              : write handshake (data_i / write_i / write_busy_o)
//   tx_active_o     : a frame is being shifted out
//   serial_o        : registered serial line, idle high
module uart_tx_buffered #(
   parameter int CLOCK_DIVIDER_WIDTH = 8
) (
   input  logic                           clock_i,
   input  logic                           reset_i,
   input  logic [CLOCK_DIVIDER_WIDTH-1:0] clock_divider_i,
   input  logic                           two_stop_bits_i,
   input  logic                           parity_bit_i,
   input  logic                           parity_even_i,
   uart_tx_buffered_if.slave              wr,
   output logic                           tx_active_o,
   output logic                           serial_o
);
   localparam int W = CLOCK_DIVIDER_WIDTH;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

   state_t       state, state_next;
   logic         hold_full;
   logic [7:0]   hold_data;
   logic [7:0]   shift_q, shift_next;
   logic [2:0]   bit_cnt;
   logic [W-1:0] timer, dm1_q, dm1_in;
   logic         two_stop_q, parity_en_q, parity_bit_q;
   logic         tick, last_stop, transfer, accept, line_next;

   // Bit period minus one, with the divider floored at 2.
   assign dm1_in    = (clock_divider_i < W'(2)) ? W'(1) : clock_divider_i - W'(1);
   assign tick      = (state != IDLE) && (timer == '0);
   assign last_stop = tick && (((state == STOP1) && !two_stop_q) || (state == STOP2));
   // Transfer and accept are mutually exclusive: one needs the holding
   // register full, the other empty, so a write on the transfer edge drops.
   assign transfer  = hold_full && ((state == IDLE) || last_stop);
   assign accept    = wr.write_i && !hold_full;

   assign wr.write_busy_o = hold_full;
   assign tx_active_o     = (state != IDLE);

   // State register
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) state <= IDLE;
      else          state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE:   if (hold_full) state_next = START;
         START:  if (tick) state_next = DATA;
         DATA:   if (tick && (bit_cnt == 3'd7)) state_next = parity_en_q ? PARITY : STOP1;
         PARITY: if (tick) state_next = STOP1;
         STOP1:  if (tick) state_next = two_stop_q ? STOP2 : (hold_full ? START : IDLE);
         STOP2:  if (tick) state_next = hold_full ? START : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output logic: the line level is computed for the state being entered so
   // serial_o can come straight from a flop without a cycle of lag.
   always_comb begin
      shift_next = shift_q;
      if (transfer)                    shift_next = hold_data;
      else if ((state == DATA) && tick) shift_next = {1'b0, shift_q[7:1]};
      line_next = 1'b1;
      case (state_next)
         START:   line_next = 1'b0;
         DATA:    line_next = shift_next[0];
         PARITY:  line_next = parity_bit_q;
         default: line_next = 1'b1;
      endcase
   end

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         hold_full    <= 1'b0;
         hold_data    <= '0;
         shift_q      <= '0;
         bit_cnt      <= '0;
         timer        <= '0;
         dm1_q        <= '0;
         two_stop_q   <= 1'b0;
         parity_en_q  <= 1'b0;
         parity_bit_q <= 1'b0;
         serial_o     <= 1'b1;
      end else begin
         shift_q  <= shift_next;
         serial_o <= line_next;

         if (transfer) hold_full <= 1'b0;
         else if (accept) begin
            hold_full <= 1'b1;
            hold_data <= wr.data_i;
         end

         if (transfer) begin
            dm1_q        <= dm1_in;
            two_stop_q   <= two_stop_bits_i;
            parity_en_q  <= parity_bit_i;
            parity_bit_q <= parity_even_i ? ^hold_data : ~^hold_data;
         end

         // Reload at every bit boundary; park at 0 when returning to IDLE.
         if (transfer)                timer <= dm1_in;
         else if (tick)               timer <= (state_next == IDLE) ? '0 : dm1_q;
         else if (state != IDLE)      timer <= timer - W'(1);

         if ((state == DATA) && tick) bit_cnt <= bit_cnt + 3'd1;
      end
   end
endmodule
